// File: rtl/uarc_responder.sv
// UARC bus receiving endpoint: acks kill/incept/send/stream, latches incept state, buffers payload words.
// Latency: acks are combinational; an accepted word is visible on o_out_data the same cycle it lands in an empty FIFO.
// Backpressure: send/stream are not acked while IDLE or while the FIFO is full; the consumer pops with o_out_valid && i_out_ready.
module uarc_responder #(
  parameter int WORD_MAG  = 5,
  parameter int DEPTH_MAG = 2
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_enable,
  input  logic                       i_kill,
  input  logic                       i_incept,
  input  logic                       i_send,
  input  logic                       i_stream,
  output logic                       o_kill_ack,
  output logic                       o_incept_ack,
  output logic                       o_send_ack,
  output logic                       o_stream_ack,
  input  logic [(1<<WORD_MAG)-1:0]   i_data,
  input  logic [(1<<WORD_MAG)-1:0]   i_incept_permission,
  input  logic [(1<<WORD_MAG)-1:0]   i_incept_address,
  output logic                       o_active,
  output logic [(1<<WORD_MAG)-1:0]   o_permission,
  output logic [(1<<WORD_MAG)-1:0]   o_address,
  output logic                       o_out_valid,
  input  logic                       i_out_ready,
  output logic [(1<<WORD_MAG)-1:0]   o_out_data,
  output logic                       o_out_stream,
  output logic [DEPTH_MAG:0]         o_count
);

  localparam int WORD_WIDTH = 1 << WORD_MAG;
  localparam int DEPTH      = 1 << DEPTH_MAG;

  localparam logic [DEPTH_MAG:0]   C_DEPTH     = (DEPTH_MAG+1)'(DEPTH);
  localparam logic [DEPTH_MAG:0]   C_COUNT_ONE = (DEPTH_MAG+1)'(1);
  localparam logic [DEPTH_MAG-1:0] C_PTR_ONE   = (DEPTH_MAG)'(1);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ACTIVE = 1'b1
  } state_t;

  // Protocol state (registered outputs live alongside the state register)
  state_t                r_state;
  logic                  r_active;
  logic [WORD_WIDTH-1:0] r_permission;
  logic [WORD_WIDTH-1:0] r_address;

  // FIFO storage: bit WORD_WIDTH tags the word as stream (1) or send (0)
  logic [WORD_WIDTH:0]   r_mem [DEPTH];
  logic [DEPTH_MAG-1:0]  r_wptr;
  logic [DEPTH_MAG-1:0]  r_rptr;
  logic [DEPTH_MAG:0]    r_count;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_kill_ack;
  logic                  w_incept_ack;
  logic                  w_send_ack;
  logic                  w_stream_ack;
  logic                  w_push;
  logic                  w_pop;
  logic [WORD_WIDTH:0]   w_push_word;
  logic [WORD_WIDTH:0]   w_head;

  // Full is judged on the registered occupancy, so a same-cycle pop never frees room for a push.
  assign w_full  = (r_count == C_DEPTH);
  assign w_empty = (r_count == '0);

  // Request arbitration: kill > incept > send > stream, all gated by the bus enable.
  // An incept while ACTIVE is never acked, so it does not block a send/stream in that cycle.
  assign w_kill_ack   = i_enable & i_kill;
  assign w_incept_ack = i_enable & ~i_kill & i_incept & (r_state == S_IDLE);
  assign w_send_ack   = i_enable & ~i_kill & ~w_incept_ack & i_send
                        & (r_state == S_ACTIVE) & ~w_full;
  assign w_stream_ack = i_enable & ~i_kill & ~w_incept_ack & ~i_send & i_stream
                        & (r_state == S_ACTIVE) & ~w_full;

  assign w_push      = w_send_ack | w_stream_ack;
  assign w_push_word = {w_stream_ack, i_data};

  // Pops continue regardless of enable; a kill flushes the FIFO and overrides any pop.
  assign w_pop = ~w_empty & i_out_ready & ~w_kill_ack;

  assign w_head = r_mem[r_rptr];

  assign o_kill_ack   = w_kill_ack;
  assign o_incept_ack = w_incept_ack;
  assign o_send_ack   = w_send_ack;
  assign o_stream_ack = w_stream_ack;

  assign o_active     = r_active;
  assign o_permission = r_permission;
  assign o_address    = r_address;

  // Head word is masked while empty so stale storage never shows on the outputs.
  assign o_out_valid  = ~w_empty;
  assign o_out_data   = w_empty ? '0   : w_head[WORD_WIDTH-1:0];
  assign o_out_stream = w_empty ? 1'b0 : w_head[WORD_WIDTH];
  assign o_count      = r_count;

  // IDLE/ACTIVE state machine with the incept permission/address latches
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_active     <= 1'b0;
      r_permission <= '0;
      r_address    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_kill_ack) begin
            r_state      <= S_IDLE;
            r_active     <= 1'b0;
            r_permission <= '0;
            r_address    <= '0;
          end else if (w_incept_ack) begin
            r_state      <= S_ACTIVE;
            r_active     <= 1'b1;
            r_permission <= i_incept_permission;
            r_address    <= i_incept_address;
          end
        end
        S_ACTIVE: begin
          if (w_kill_ack) begin
            r_state      <= S_IDLE;
            r_active     <= 1'b0;
            r_permission <= '0;
            r_address    <= '0;
          end
        end
        default: begin
          r_state      <= S_IDLE;
          r_active     <= 1'b0;
          r_permission <= '0;
          r_address    <= '0;
        end
      endcase
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally modulo DEPTH
  always_ff @(posedge i_clk) begin
    if (i_reset || w_kill_ack) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + C_PTR_ONE;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + C_PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + C_COUNT_ONE;
        2'b01:   r_count <= r_count - C_COUNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO storage write; contents need no reset because the head is masked when empty
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= w_push_word;
    end
  end

endmodule

// File: tb/tb_uarc_responder.sv
module tb_uarc_responder;

  localparam int WW = 32;

  logic          clk;
  logic          reset;
  logic          enable;
  logic          kill, incept, send, stream;
  logic          kill_ack, incept_ack, send_ack, stream_ack;
  logic [WW-1:0] data, perm_in, addr_in;
  logic          active;
  logic [WW-1:0] permission, address;
  logic          out_valid, out_ready;
  logic [WW-1:0] out_data;
  logic          out_stream;
  logic [2:0]    count;

  int n_checks = 0;
  int n_errors = 0;

  // Scoreboard of {stream_flag, data} words expected at the FIFO head
  logic [WW:0] sb_q[$];

  uarc_responder #(.WORD_MAG(5), .DEPTH_MAG(2)) dut (
    .i_clk(clk), .i_reset(reset), .i_enable(enable),
    .i_kill(kill), .i_incept(incept), .i_send(send), .i_stream(stream),
    .o_kill_ack(kill_ack), .o_incept_ack(incept_ack),
    .o_send_ack(send_ack), .o_stream_ack(stream_ack),
    .i_data(data), .i_incept_permission(perm_in), .i_incept_address(addr_in),
    .o_active(active), .o_permission(permission), .o_address(address),
    .o_out_valid(out_valid), .i_out_ready(out_ready),
    .o_out_data(out_data), .o_out_stream(out_stream), .o_count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Consumer-side scoreboard: every pop must match the oldest expected word
  always @(negedge clk) begin
    if (!reset && !kill_ack && out_valid && out_ready) begin
      n_checks++;
      if (sb_q.size() == 0) begin
        n_errors++;
        $display("FAIL pop_unexpected: got %h, scoreboard empty", {out_stream, out_data});
      end else begin
        logic [WW:0] exp_w;
        exp_w = sb_q.pop_front();
        if ({out_stream, out_data} !== exp_w) begin
          n_errors++;
          $display("FAIL pop_order: got %h expected %h", {out_stream, out_data}, exp_w);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!out_valid) begin
        done = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    out_ready = 1'b0;
    n_checks++;
    if (!done || sb_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: done=%0d left=%0d expected done=1 left=0", done, sb_q.size());
    end
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; kill = 0; incept = 0; send = 0; stream = 0;
    data = '0; perm_in = '0; addr_in = '0; out_ready = 1'b0;
    step(); step();
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({active, count, out_valid} !== 5'b0) begin
      n_errors++;
      $display("FAIL reset_state: active=%b count=%0d valid=%b expected 0", active, count, out_valid);
    end
    n_checks++;
    if ({permission, address} !== 64'h0) begin
      n_errors++;
      $display("FAIL reset_regs: perm=%h addr=%h expected 0", permission, address);
    end
    n_checks++;
    if ({kill_ack, incept_ack, send_ack, stream_ack} !== 4'b0) begin
      n_errors++;
      $display("FAIL reset_acks: got %b expected 0000", {kill_ack, incept_ack, send_ack, stream_ack});
    end
    step();
  endtask

  task automatic test_incept(input logic [WW-1:0] p, input logic [WW-1:0] a);
    enable = 1'b1; incept = 1'b1; perm_in = p; addr_in = a;
    @(negedge clk);
    n_checks++;
    if ({kill_ack, incept_ack, send_ack, stream_ack} !== 4'b0100) begin
      n_errors++;
      $display("FAIL incept_ack: got %b expected 0100", {kill_ack, incept_ack, send_ack, stream_ack});
    end
    step();
    incept = 1'b0; perm_in = '0; addr_in = '0;
    @(negedge clk);
    n_checks++;
    if ({active, permission, address} !== {1'b1, p, a}) begin
      n_errors++;
      $display("FAIL incept_latch: active=%b perm=%h addr=%h expected 1 %h %h", active, permission, address, p, a);
    end
    step();
  endtask

  task automatic test_full();
    logic [WW-1:0] vals [4];
    vals[0] = 32'hA; vals[1] = 32'hB; vals[2] = 32'hC; vals[3] = 32'hD;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send = 1'b1; data = vals[i];
      @(negedge clk);
      n_checks++;
      if (send_ack !== 1'b1) begin
        n_errors++;
        $display("FAIL full_fill_ack%0d: got %b expected 1", i, send_ack);
      end
      if (send_ack) sb_q.push_back({1'b0, data});
      step();
    end
    data = 32'hE;
    @(negedge clk);
    n_checks++;
    if (count !== 3'd4 || send_ack !== 1'b0) begin
      n_errors++;
      $display("FAIL full_hold: count=%0d ack=%b expected 4 0", count, send_ack);
    end
    step();
    out_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (send_ack !== 1'b0) begin
      n_errors++;
      $display("FAIL full_pop_same_cycle: ack=%b expected 0", send_ack);
    end
    step();
    out_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if (send_ack !== 1'b1 || count !== 3'd3) begin
      n_errors++;
      $display("FAIL full_retry: ack=%b count=%0d expected 1 3", send_ack, count);
    end
    if (send_ack) sb_q.push_back({1'b0, data});
    step();
    send = 1'b0;
    @(negedge clk);
    n_checks++;
    if (count !== 3'd4) begin
      n_errors++;
      $display("FAIL full_refill: count=%0d expected 4", count);
    end
    step();
    drain();
  endtask

  task automatic test_priority();
    send = 1'b1; stream = 1'b1; data = 32'h55;
    @(negedge clk);
    n_checks++;
    if ({send_ack, stream_ack} !== 2'b10) begin
      n_errors++;
      $display("FAIL prio_acks: got %b expected 10", {send_ack, stream_ack});
    end
    if (send_ack) sb_q.push_back({stream_ack, data});
    step();
    send = 1'b0; stream = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({out_valid, out_stream, out_data} !== {1'b1, 1'b0, 32'h55}) begin
      n_errors++;
      $display("FAIL prio_fwft: valid=%b stream=%b data=%h expected 1 0 00000055", out_valid, out_stream, out_data);
    end
    step();
    stream = 1'b1; data = 32'h66;
    @(negedge clk);
    n_checks++;
    if ({send_ack, stream_ack} !== 2'b01) begin
      n_errors++;
      $display("FAIL stream_ack: got %b expected 01", {send_ack, stream_ack});
    end
    if (stream_ack) sb_q.push_back({1'b1, data});
    step();
    stream = 1'b0;
    drain();
  endtask

  task automatic fill(input int n, input logic [WW-1:0] base);
    for (int i = 0; i < n; i++) begin
      send = 1'b1; data = base + WW'(i);
      @(negedge clk);
      if (send_ack) sb_q.push_back({1'b0, data});
      step();
    end
    send = 1'b0;
  endtask

  task automatic test_kill();
    out_ready = 1'b0;
    fill(3, 32'h100);
    kill = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({kill_ack, incept_ack, send_ack, stream_ack} !== 4'b1000) begin
      n_errors++;
      $display("FAIL kill_ack: got %b expected 1000", {kill_ack, incept_ack, send_ack, stream_ack});
    end
    step();
    kill = 1'b0; out_ready = 1'b0;
    sb_q.delete();
    @(negedge clk);
    n_checks++;
    if ({count, out_valid, active, permission, address} !== '0) begin
      n_errors++;
      $display("FAIL kill_state: count=%0d valid=%b active=%b perm=%h addr=%h expected 0", count, out_valid, active, permission, address);
    end
    step();
    send = 1'b1; data = 32'h9;
    @(negedge clk);
    n_checks++;
    if (send_ack !== 1'b0) begin
      n_errors++;
      $display("FAIL kill_then_send: ack=%b expected 0", send_ack);
    end
    step();
    send = 1'b0;
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    fill(2, 32'h200);
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      send = 1'b1; data = 32'h300 + WW'(i);
      @(negedge clk);
      n_checks++;
      if (send_ack !== 1'b1 || count !== 3'd2) begin
        n_errors++;
        $display("FAIL b2b_%0d: ack=%b count=%0d expected 1 2", i, send_ack, count);
      end
      if (send_ack) sb_q.push_back({1'b0, data});
      step();
    end
    send = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if (count !== 3'd2) begin
      n_errors++;
      $display("FAIL b2b_final_count: count=%0d expected 2", count);
    end
    step();
    drain();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    fill(3, 32'h400);
    @(negedge clk);
    n_checks++;
    if (count !== 3'd3 || active !== 1'b1) begin
      n_errors++;
      $display("FAIL pre_reset: count=%0d active=%b expected 3 1", count, active);
    end
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    sb_q.delete();
    @(negedge clk);
    n_checks++;
    if ({active, permission, address, count, out_valid, out_data, out_stream,
         kill_ack, incept_ack, send_ack, stream_ack} !== '0) begin
      n_errors++;
      $display("FAIL mid_reset: active=%b perm=%h addr=%h count=%0d valid=%b data=%h stream=%b expected all 0",
               active, permission, address, count, out_valid, out_data, out_stream);
    end
    step();
    test_incept(32'hCAFE0001, 32'h0000BEEF);
  endtask

  initial begin
    test_reset();
    test_incept(32'hFFFF0000, 32'h00001234);
    test_full();
    test_priority();
    test_kill();
    test_incept(32'h0F0F0F0F, 32'h00005678);
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
